// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops to a requested state, then checks the
// Q feedback and reports done/mismatch with a saturating error count.
`timescale 1ns/1ps
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic             toggle_pref,
  input  logic             clr_req,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             ff_rst,
  input  logic [WIDTH-1:0] Q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
);

  // state | meaning
  // IDLE  | waiting for a target or clear request
  // DRIVE | J/K/ff_rst presented; flip-flops capture at the end of this cycle
  // CHECK | Q_fb settled; compared against the expected word
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] expected, expected_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt, j_exc, k_exc, tp_vec;
  logic             ff_rst_nxt, done_nxt, mismatch_nxt, q_differs;
  logic [CNT_W-1:0] err_nxt;

  assign tgt_ready = (state == IDLE) & ~clr_req;

  // Excitation table: changing bits get J=1 (0->1) or K=1 (1->0); the other
  // input is either "don't care" driven as 0, or 1 when toggling is preferred.
  assign tp_vec    = {WIDTH{toggle_pref}};
  assign j_exc     = (~Q_fb & tgt_data) | (Q_fb & ~tgt_data & tp_vec);
  assign k_exc     = (Q_fb & ~tgt_data) | (~Q_fb & tgt_data & tp_vec);
  assign q_differs = (Q_fb != expected);

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    j_nxt        = '0;
    k_nxt        = '0;
    ff_rst_nxt   = 1'b0;
    done_nxt     = 1'b0;
    mismatch_nxt = mismatch;
    err_nxt      = err_count;
    case (state)
      IDLE: begin
        if (clr_req) begin
          expected_nxt = '0;
          ff_rst_nxt   = 1'b1;
          state_nxt    = DRIVE;
        end else if (tgt_valid) begin
          expected_nxt = tgt_data;
          j_nxt        = j_exc;
          k_nxt        = k_exc;
          state_nxt    = DRIVE;
        end
      end
      DRIVE: state_nxt = CHECK;
      CHECK: begin
        done_nxt     = 1'b1;
        mismatch_nxt = q_differs;
        if (q_differs && !(&err_count))
          err_nxt = err_count + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      expected  <= '0;
      J         <= '0;
      K         <= '0;
      ff_rst    <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      J         <= j_nxt;
      K         <= k_nxt;
      ff_rst    <= ff_rst_nxt;
      done      <= done_nxt;
      mismatch  <= mismatch_nxt;
      err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK flip-flop bank
// on the far side and a scoreboard of expected check results.
`timescale 1ns/1ps
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          rst, tgt_valid, toggle_pref, clr_req;
  logic [W-1:0]  tgt_data, J, K, Q_fb;
  logic          tgt_ready, ff_rst, done, mismatch;
  logic [CW-1:0] err_count;

  jk_excitation_driver #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .toggle_pref(toggle_pref), .clr_req(clr_req),
    .J(J), .K(K), .ff_rst(ff_rst), .Q_fb(Q_fb), .done(done),
    .mismatch(mismatch), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  // External flip-flop bank, with optional stuck-at-0 feedback bits
  logic [W-1:0] q_ff, stuck, preset_val;
  logic         preset_en;
  always @(posedge Clk) begin
    if (preset_en) q_ff <= preset_val;
    else if (ff_rst) q_ff <= '0;
    else
      for (int i = 0; i < W; i++)
        case ({J[i], K[i]})
          2'b01: q_ff[i] <= 1'b0;
          2'b10: q_ff[i] <= 1'b1;
          2'b11: q_ff[i] <= ~q_ff[i];
          default: q_ff[i] <= q_ff[i];
        endcase
  end
  assign Q_fb = q_ff & ~stuck;

  typedef struct packed { logic mm; logic [CW-1:0] ec; } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, err_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk); #1;
  endtask

  function automatic logic [1:0] exc(input logic q, input logic t, input logic tp);
    case ({q, t})
      2'b01:   return {1'b1, tp};
      2'b10:   return {tp, 1'b1};
      default: return 2'b00;
    endcase
  endfunction

  task automatic wait_ready;
    int n = 0;
    while (tgt_ready !== 1'b1 && n < 10) begin step; n++; end
    chk("tgt_ready_wait", tgt_ready, 1);
  endtask

  task automatic push_exp(input logic clr, input logic [W-1:0] t);
    exp_t e;
    e.mm = clr ? 1'b0 : ((t & ~stuck) != t);
    if (e.mm && err_model < SAT) err_model++;
    e.ec = err_model[CW-1:0];
    sb.push_back(e);
  endtask

  task automatic check_done(input logic [W-1:0] q_exp);
    exp_t e;
    chk("done", done, 1);
    chk("tgt_ready_at_done", tgt_ready, 1);
    chk("Q_after", Q_fb, q_exp);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mismatch", mismatch, e.mm);
      chk("err_count", err_count, e.ec);
    end else chk("scoreboard_empty", sb.size(), 1);
  endtask

  task automatic do_op(input logic clr, input logic [W-1:0] t, input logic tp);
    logic [W-1:0] ej, ek;
    wait_ready();
    ej = '0; ek = '0;
    if (!clr) for (int i = 0; i < W; i++) {ej[i], ek[i]} = exc(Q_fb[i], t[i], tp);
    push_exp(clr, t);
    clr_req = clr; tgt_valid = !clr; tgt_data = t; toggle_pref = tp;
    step;
    clr_req = 1'b0; tgt_valid = 1'b0;
    chk("J_drive", J, ej);
    chk("K_drive", K, ek);
    chk("ff_rst_drive", ff_rst, clr);
    step;
    chk("JK_check_idle", {J, K, ff_rst}, 0);
    chk("done_early", done, 0);
    step;
    check_done(clr ? '0 : (t & ~stuck));
  endtask

  initial begin
    logic [W-1:0] ej, ek;
    rst = 1'b1; tgt_valid = 1'b0; toggle_pref = 1'b0; clr_req = 1'b0;
    tgt_data = '0; stuck = '0; preset_en = 1'b1; preset_val = 4'b1010;
    step; step;
    chk("rst_J", J, 0);
    chk("rst_K", K, 0);
    chk("rst_ff_rst", ff_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_tgt_ready", tgt_ready, 1);
    chk("preset_Q", Q_fb, 4'b1010);
    rst = 1'b0; preset_en = 1'b0;
    step;

    do_op(1'b1, 4'b0000, 1'b0);
    do_op(1'b0, 4'b0110, 1'b0);
    do_op(1'b0, 4'b1010, 1'b1);

    stuck = 4'b0001;
    for (int n = 0; n < 300; n++) do_op(1'b0, 4'b0001, 1'b0);
    chk("err_saturated", err_count, SAT);
    step;
    chk("done_one_cycle", done, 0);
    chk("mismatch_hold", mismatch, 1);
    stuck = '0;

    // Clear and target together: clear wins, target waits until after done
    wait_ready();
    push_exp(1'b1, 4'b0000);
    clr_req = 1'b1; tgt_valid = 1'b1; tgt_data = 4'b0101; toggle_pref = 1'b0;
    #1;
    chk("ready_during_clr", tgt_ready, 0);
    step;
    clr_req = 1'b0;
    chk("clr_ff_rst", ff_rst, 1);
    chk("clr_JK", {J, K}, 0);
    chk("ready_in_drive", tgt_ready, 0);
    step; step;
    check_done(4'b0000);
    ej = '0; ek = '0;
    for (int i = 0; i < W; i++) {ej[i], ek[i]} = exc(Q_fb[i], tgt_data[i], 1'b0);
    push_exp(1'b0, 4'b0101);
    step;
    tgt_valid = 1'b0;
    chk("held_tgt_J", J, ej);
    chk("held_tgt_K", K, ek);
    step; step;
    check_done(4'b0101);

    // Reset while in CHECK aborts the transfer
    wait_ready();
    tgt_valid = 1'b1; tgt_data = 4'b1111; toggle_pref = 1'b1;
    step;
    tgt_valid = 1'b0;
    step;
    rst = 1'b1; #1;
    chk("abort_JKrst", {J, K, ff_rst}, 0);
    chk("abort_done", done, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_mismatch", mismatch, 0);
    err_model = 0;
    step;
    rst = 1'b0; #1;
    chk("ready_after_rst", tgt_ready, 1);
    step;
    chk("no_done_after_rst", done, 0);
    chk("ready_idle", tgt_ready, 1);

    do_op(1'b0, 4'b0011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
